// File: rtl/afu_tx_ab_commit_arb.sv
// AFU TX A/B merge with packet-atomic round-robin arbitration.
// Returns a local write commit on RX B for every TX A memory write.
module afu_tx_ab_commit_arb #(
  parameter int DATA_W       = 512,
  parameter int USER_W       = 10,
  parameter int COMMIT_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tx_a_tvalid,
  output logic                tx_a_tready,
  input  logic                tx_a_tlast,
  input  logic [DATA_W-1:0]   tx_a_tdata,
  input  logic [DATA_W/8-1:0] tx_a_tkeep,
  input  logic [USER_W-1:0]   tx_a_tuser,
  input  logic                tx_b_tvalid,
  output logic                tx_b_tready,
  input  logic                tx_b_tlast,
  input  logic [DATA_W-1:0]   tx_b_tdata,
  input  logic [DATA_W/8-1:0] tx_b_tkeep,
  input  logic [USER_W-1:0]   tx_b_tuser,
  output logic                out_tvalid,
  input  logic                out_tready,
  output logic                out_tlast,
  output logic [DATA_W-1:0]   out_tdata,
  output logic [DATA_W/8-1:0] out_tkeep,
  output logic [USER_W-1:0]   out_tuser,
  output logic                rxb_tvalid,
  input  logic                rxb_tready,
  output logic                rxb_tlast,
  output logic [DATA_W-1:0]   rxb_tdata,
  output logic [DATA_W/8-1:0] rxb_tkeep,
  output logic [USER_W-1:0]   rxb_tuser
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int BEAT_W = DATA_W + KEEP_W + USER_W + 1;
  localparam int PTR_W  = $clog2(COMMIT_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(COMMIT_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOCK_A,
    LOCK_B
  } state_t;

  state_t state, state_nxt;
  logic   last_b, last_b_nxt;

  logic              sel_a, sel_b;
  logic              elig_a, elig_b;
  logic              acc_a, acc_b;
  logic              skid_full;
  logic [BEAT_W-1:0] in_beat;

  logic [BEAT_W-1:0] skid [2];
  logic              skid_wp, skid_rp;
  logic [1:0]        skid_cnt;
  logic              skid_push, skid_pop;

  logic [7:0]        cmem [COMMIT_DEPTH];
  logic [PTR_W-1:0]  c_wp, c_rp;
  logic [CNT_W-1:0]  c_cnt;
  logic              c_push, c_pop;

  logic              pend_wr;
  logic [7:0]        pend_tag;
  logic              sop_a, is_wr, wr_now;
  logic [7:0]        a_fmt, tag_now;

  assign elig_a    = tx_a_tvalid && (c_cnt < FULL_CNT);
  assign elig_b    = tx_b_tvalid;
  assign skid_full = (skid_cnt == 2'd2);

  // Grant selection and next-state for the packet-lock arbiter.
  always_comb begin
    sel_a      = 1'b0;
    sel_b      = 1'b0;
    state_nxt  = state;
    last_b_nxt = last_b;
    unique case (state)
      IDLE: begin
        sel_a = elig_a && (!elig_b || last_b);
        sel_b = elig_b && (!elig_a || !last_b);
        if (acc_a) begin
          if (tx_a_tlast) last_b_nxt = 1'b0;
          else            state_nxt  = LOCK_A;
        end else if (acc_b) begin
          if (tx_b_tlast) last_b_nxt = 1'b1;
          else            state_nxt  = LOCK_B;
        end
      end
      LOCK_A: begin
        sel_a = 1'b1;
        if (acc_a && tx_a_tlast) begin
          state_nxt  = IDLE;
          last_b_nxt = 1'b0;
        end
      end
      LOCK_B: begin
        sel_b = 1'b1;
        if (acc_b && tx_b_tlast) begin
          state_nxt  = IDLE;
          last_b_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshakes are held off while reset is asserted.
  assign tx_a_tready = rst_n && sel_a && !skid_full;
  assign tx_b_tready = rst_n && sel_b && !skid_full;
  assign acc_a       = tx_a_tvalid && tx_a_tready;
  assign acc_b       = tx_b_tvalid && tx_b_tready;

  assign in_beat = sel_a ?
    {tx_a_tlast, tx_a_tuser, tx_a_tkeep, tx_a_tdata} :
    {tx_b_tlast, tx_b_tuser, tx_b_tkeep, tx_b_tdata};

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      last_b <= 1'b1;
    end else begin
      state  <= state_nxt;
      last_b <= last_b_nxt;
    end
  end

  assign skid_push = acc_a || acc_b;
  assign skid_pop  = out_tvalid && out_tready;
  assign out_tvalid = (skid_cnt != 2'd0);
  assign {out_tlast, out_tuser, out_tkeep, out_tdata} = skid[skid_rp];

  // Two-entry output skid buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_wp  <= 1'b0;
      skid_rp  <= 1'b0;
      skid_cnt <= 2'd0;
    end else begin
      if (skid_push) skid_wp <= ~skid_wp;
      if (skid_pop)  skid_rp <= ~skid_rp;
      unique case ({skid_push, skid_pop})
        2'b10:   skid_cnt <= skid_cnt + 2'd1;
        2'b01:   skid_cnt <= skid_cnt - 2'd1;
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

  // Skid payload storage.
  always_ff @(posedge clk) begin
    if (skid_push) skid[skid_wp] <= in_beat;
  end

  assign a_fmt   = tx_a_tdata[31:24];
  assign is_wr   = a_fmt[6] && (a_fmt[4:0] == 5'd0);
  assign sop_a   = (state == IDLE) && acc_a;
  assign wr_now  = sop_a ? is_wr : pend_wr;
  assign tag_now = sop_a ? tx_a_tdata[47:40] : pend_tag;
  assign c_push  = acc_a && tx_a_tlast && wr_now;
  assign c_pop   = rxb_tvalid && rxb_tready;

  // Latch write flag and tag at the SOP of each TX A packet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_wr  <= 1'b0;
      pend_tag <= 8'd0;
    end else if (sop_a) begin
      pend_wr  <= is_wr;
      pend_tag <= tx_a_tdata[47:40];
    end
  end

  // Commit FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_wp  <= '0;
      c_rp  <= '0;
      c_cnt <= '0;
    end else begin
      if (c_push) c_wp <= c_wp + 1'b1;
      if (c_pop)  c_rp <= c_rp + 1'b1;
      unique case ({c_push, c_pop})
        2'b10:   c_cnt <= c_cnt + 1'b1;
        2'b01:   c_cnt <= c_cnt - 1'b1;
        default: c_cnt <= c_cnt;
      endcase
    end
  end

  // Commit tag storage.
  always_ff @(posedge clk) begin
    if (c_push) cmem[c_wp] <= tag_now;
  end

  // Space is reserved at SOP, so a push can never meet a full FIFO.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(c_push && c_cnt == FULL_CNT));
  end

  assign rxb_tvalid = (c_cnt != '0);
  assign rxb_tlast  = 1'b1;
  assign rxb_tuser  = '0;

  // Dataless completion header carrying the write's tag.
  always_comb begin
    rxb_tdata        = '0;
    rxb_tdata[31:24] = 8'h0A;
    rxb_tdata[47:40] = cmem[c_rp];
    rxb_tkeep        = '0;
    rxb_tkeep[31:0]  = '1;
  end

endmodule
